// File: rtl/combination_pkg.sv
// +----------------------------------------------------------------------------+
// | combination_pkg : shared types and width helpers for combination_ctrl     |
// | Revision 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package combination_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_SELF_RD   = 4'd1,
    ST_SELF_WAIT = 4'd2,
    ST_SELF_WR   = 4'd3,
    ST_FETCH     = 4'd4,
    ST_LATCH     = 4'd5,
    ST_FWD_RD    = 4'd6,
    ST_FWD_WAIT  = 4'd7,
    ST_FWD_WR    = 4'd8,
    ST_REV_RD    = 4'd9,
    ST_REV_WAIT  = 4'd10,
    ST_REV_WR    = 4'd11,
    ST_DONE      = 4'd12
  } comb_state_t;

  typedef enum logic [1:0] {
    OP_SELF = 2'd0,
    OP_FWD  = 2'd1,
    OP_REV  = 2'd2,
    OP_NONE = 2'd3
  } op_sel_t;

  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

  function automatic int max1(input int value);
    return (value < 1) ? 1 : value;
  endfunction

  function automatic op_sel_t state_op(input comb_state_t s);
    case (s)
      ST_SELF_RD, ST_SELF_WAIT, ST_SELF_WR: return OP_SELF;
      ST_FWD_RD, ST_FWD_WAIT, ST_FWD_WR:    return OP_FWD;
      ST_REV_RD, ST_REV_WAIT, ST_REV_WR:    return OP_REV;
      default:                              return OP_NONE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/op_sequencer.sv
// +----------------------------------------------------------------------------+
// | op_sequencer : read-latency and feature-chunk counters for one RD/WAIT/WR |
// | Revision 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module op_sequencer
  import combination_pkg::*;
#(
  parameter int FEAT_CHUNKS  = 1,
  parameter int READ_LATENCY = 1,
  localparam int CW = clog2_min1(FEAT_CHUNKS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_clear,
  input  logic          i_rd,
  input  logic          i_wait,
  input  logic          i_wr,
  input  logic          i_wr_ready,
  output logic          o_wait_done,
  output logic          o_wr_fire,
  output logic          o_last_chunk,
  output logic [CW-1:0] o_chunk
);

  localparam int LW = clog2_min1(READ_LATENCY);

  logic [LW-1:0] r_lat;
  logic [CW-1:0] r_chunk;

  assign o_wr_fire    = i_wr && i_wr_ready;
  assign o_last_chunk = (r_chunk == CW'(FEAT_CHUNKS - 1));
  // WAIT lasts READ_LATENCY-1 cycles; the counter restarts on every read
  assign o_wait_done  = i_wait && (r_lat == LW'(READ_LATENCY - 2));
  assign o_chunk      = r_chunk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lat <= '0;
    end else if (i_rd) begin
      r_lat <= '0;
    end else if (i_wait) begin
      r_lat <= r_lat + LW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_chunk <= '0;
    end else if (i_clear) begin
      r_chunk <= '0;
    end else if (o_wr_fire) begin
      r_chunk <= o_last_chunk ? '0 : r_chunk + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/combination_ctrl.sv
// +----------------------------------------------------------------------------+
// | combination_ctrl : streams COO edges and issues FM_WM reads / ADJ writes  |
// | Revision 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module combination_ctrl
  import combination_pkg::*;
#(
  parameter int MAX_EDGES    = 64,
  parameter int NUM_NODES    = 16,
  parameter int FEAT_CHUNKS  = 1,
  parameter int READ_LATENCY = 1,
  parameter int UNDIRECTED   = 1,
  parameter int SELF_LOOPS   = 1,
  localparam int EW = $clog2(MAX_EDGES + 1),
  localparam int NW = clog2_min1(NUM_NODES),
  localparam int CW = clog2_min1(FEAT_CHUNKS),
  localparam int AW = max1(EW - 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [EW-1:0] num_edges,
  output logic          coo_rd_en,
  output logic [AW-1:0] coo_addr,
  input  logic [NW-1:0] coo_src,
  input  logic [NW-1:0] coo_dst,
  output logic          fm_rd_en,
  output logic [NW-1:0] fm_rd_addr,
  output logic          adj_wr_en,
  output logic [NW-1:0] adj_wr_addr,
  output logic [CW-1:0] feat_chunk,
  input  logic          adj_wr_ready,
  output logic          busy,
  output logic          done_comb
);

  comb_state_t   r_state;
  comb_state_t   w_next;
  op_sel_t       w_op;
  logic [EW-1:0] r_num;
  logic [EW-1:0] r_edge;
  logic [NW-1:0] r_node;
  logic [NW-1:0] r_src;
  logic [NW-1:0] r_dst;
  logic [EW-1:0] w_num_clamped;
  logic          w_in_rd, w_in_wait, w_in_wr;
  logic          w_wait_done, w_wr_fire, w_last_chunk;
  logic          w_last_node, w_last_edge, w_self_edge;
  logic [CW-1:0] w_chunk;

  assign w_num_clamped = (num_edges > EW'(MAX_EDGES)) ? EW'(MAX_EDGES) : num_edges;
  assign w_op          = state_op(r_state);
  assign w_in_rd       = (r_state == ST_SELF_RD)   || (r_state == ST_FWD_RD)   || (r_state == ST_REV_RD);
  assign w_in_wait     = (r_state == ST_SELF_WAIT) || (r_state == ST_FWD_WAIT) || (r_state == ST_REV_WAIT);
  assign w_in_wr       = (r_state == ST_SELF_WR)   || (r_state == ST_FWD_WR)   || (r_state == ST_REV_WR);
  assign w_last_node   = (r_node == NW'(NUM_NODES - 1));
  assign w_last_edge   = (r_edge == r_num - EW'(1));
  assign w_self_edge   = (r_src == r_dst);

  op_sequencer #(
    .FEAT_CHUNKS  (FEAT_CHUNKS),
    .READ_LATENCY (READ_LATENCY)
  ) u_op_sequencer (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_clear      (r_state == ST_IDLE),
    .i_rd         (w_in_rd),
    .i_wait       (w_in_wait),
    .i_wr         (w_in_wr),
    .i_wr_ready   (adj_wr_ready),
    .o_wait_done  (w_wait_done),
    .o_wr_fire    (w_wr_fire),
    .o_last_chunk (w_last_chunk),
    .o_chunk      (w_chunk)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (SELF_LOOPS != 0)         w_next = ST_SELF_RD;
          else if (w_num_clamped != 0) w_next = ST_FETCH;
          else                         w_next = ST_DONE;
        end
      end
      ST_SELF_RD:   w_next = (READ_LATENCY > 1) ? ST_SELF_WAIT : ST_SELF_WR;
      ST_SELF_WAIT: if (w_wait_done) w_next = ST_SELF_WR;
      ST_SELF_WR: begin
        if (w_wr_fire) begin
          if (!w_last_chunk || !w_last_node) w_next = ST_SELF_RD;
          else                               w_next = (r_num != '0) ? ST_FETCH : ST_DONE;
        end
      end
      ST_FETCH:    w_next = ST_LATCH;
      ST_LATCH:    w_next = ST_FWD_RD;
      ST_FWD_RD:   w_next = (READ_LATENCY > 1) ? ST_FWD_WAIT : ST_FWD_WR;
      ST_FWD_WAIT: if (w_wait_done) w_next = ST_FWD_WR;
      ST_FWD_WR: begin
        // a COO self-edge is already its own transpose, so it gets no reverse pass
        if (w_wr_fire) begin
          if (!w_last_chunk)                       w_next = ST_FWD_RD;
          else if (UNDIRECTED != 0 && !w_self_edge) w_next = ST_REV_RD;
          else                                     w_next = w_last_edge ? ST_DONE : ST_FETCH;
        end
      end
      ST_REV_RD:   w_next = (READ_LATENCY > 1) ? ST_REV_WAIT : ST_REV_WR;
      ST_REV_WAIT: if (w_wait_done) w_next = ST_REV_WR;
      ST_REV_WR: begin
        if (w_wr_fire) begin
          if (!w_last_chunk) w_next = ST_REV_RD;
          else               w_next = w_last_edge ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE:     w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_num  <= '0;
      r_edge <= '0;
      r_node <= '0;
      r_src  <= '0;
      r_dst  <= '0;
    end else begin
      if (r_state == ST_IDLE && start) begin
        r_num  <= w_num_clamped;
        r_edge <= '0;
        r_node <= '0;
      end
      if (r_state == ST_SELF_WR && w_wr_fire && w_last_chunk && !w_last_node) begin
        r_node <= r_node + NW'(1);
      end
      if (r_state == ST_LATCH) begin
        r_src <= coo_src;
        r_dst <= coo_dst;
      end
      if ((r_state == ST_FWD_WR || r_state == ST_REV_WR) && w_next == ST_FETCH) begin
        r_edge <= r_edge + EW'(1);
      end
    end
  end

  always_comb begin
    fm_rd_addr  = '0;
    adj_wr_addr = '0;
    case (w_op)
      OP_SELF: begin fm_rd_addr = r_node; adj_wr_addr = r_node; end
      OP_FWD:  begin fm_rd_addr = r_src;  adj_wr_addr = r_dst;  end
      OP_REV:  begin fm_rd_addr = r_dst;  adj_wr_addr = r_src;  end
      default: begin fm_rd_addr = '0;     adj_wr_addr = '0;     end
    endcase
  end

  assign coo_rd_en  = (r_state == ST_FETCH);
  assign coo_addr   = (r_state == ST_FETCH) ? r_edge[AW-1:0] : '0;
  assign fm_rd_en   = w_in_rd;
  assign adj_wr_en  = w_in_wr;
  assign feat_chunk = w_chunk;
  assign busy       = (r_state != ST_IDLE);
  assign done_comb  = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_combination_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_combination_ctrl : directed checks of combination_ctrl, two configs    |
// | Revision 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_combination_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       sel;
  logic       ready;
  logic [6:0] num_edges;

  always #5 clk = ~clk;

  // instance A: 4 nodes, self loops, undirected, latency 1, one chunk
  logic       a_coo_rd_en, a_fm_rd_en, a_adj_wr_en, a_busy, a_done;
  logic [5:0] a_coo_addr;
  logic [1:0] a_fm_rd_addr, a_adj_wr_addr, a_coo_src, a_coo_dst;
  logic [0:0] a_feat_chunk;
  // instance B: 4 nodes, directed, no self loops, latency 3, two chunks
  logic       b_coo_rd_en, b_fm_rd_en, b_adj_wr_en, b_busy, b_done;
  logic [5:0] b_coo_addr;
  logic [1:0] b_fm_rd_addr, b_adj_wr_addr, b_coo_src, b_coo_dst;
  logic [0:0] b_feat_chunk;

  logic [1:0] mem_src [0:63];
  logic [1:0] mem_dst [0:63];

  combination_ctrl #(
    .MAX_EDGES(64), .NUM_NODES(4), .FEAT_CHUNKS(1), .READ_LATENCY(1),
    .UNDIRECTED(1), .SELF_LOOPS(1)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start & ~sel), .num_edges(num_edges),
    .coo_rd_en(a_coo_rd_en), .coo_addr(a_coo_addr), .coo_src(a_coo_src), .coo_dst(a_coo_dst),
    .fm_rd_en(a_fm_rd_en), .fm_rd_addr(a_fm_rd_addr), .adj_wr_en(a_adj_wr_en),
    .adj_wr_addr(a_adj_wr_addr), .feat_chunk(a_feat_chunk), .adj_wr_ready(ready),
    .busy(a_busy), .done_comb(a_done)
  );

  combination_ctrl #(
    .MAX_EDGES(64), .NUM_NODES(4), .FEAT_CHUNKS(2), .READ_LATENCY(3),
    .UNDIRECTED(0), .SELF_LOOPS(0)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start & sel), .num_edges(num_edges),
    .coo_rd_en(b_coo_rd_en), .coo_addr(b_coo_addr), .coo_src(b_coo_src), .coo_dst(b_coo_dst),
    .fm_rd_en(b_fm_rd_en), .fm_rd_addr(b_fm_rd_addr), .adj_wr_en(b_adj_wr_en),
    .adj_wr_addr(b_adj_wr_addr), .feat_chunk(b_feat_chunk), .adj_wr_ready(ready),
    .busy(b_busy), .done_comb(b_done)
  );

  always @(posedge clk) begin
    if (a_coo_rd_en) begin
      a_coo_src <= mem_src[a_coo_addr];
      a_coo_dst <= mem_dst[a_coo_addr];
    end
    if (b_coo_rd_en) begin
      b_coo_src <= mem_src[b_coo_addr];
      b_coo_dst <= mem_dst[b_coo_addr];
    end
  end

  wire [15:0] a_outs = {a_coo_rd_en, a_coo_addr, a_fm_rd_en, a_fm_rd_addr, a_adj_wr_en,
                        a_adj_wr_addr, a_feat_chunk, a_busy, a_done};
  wire [15:0] b_outs = {b_coo_rd_en, b_coo_addr, b_fm_rd_en, b_fm_rd_addr, b_adj_wr_en,
                        b_adj_wr_addr, b_feat_chunk, b_busy, b_done};
  wire [15:0] m_outs     = sel ? b_outs : a_outs;
  wire        m_coo_rd   = sel ? b_coo_rd_en : a_coo_rd_en;
  wire        m_rd_en    = sel ? b_fm_rd_en : a_fm_rd_en;
  wire [1:0]  m_rd_addr  = sel ? b_fm_rd_addr : a_fm_rd_addr;
  wire        m_wr_en    = sel ? b_adj_wr_en : a_adj_wr_en;
  wire [1:0]  m_wr_addr  = sel ? b_adj_wr_addr : a_adj_wr_addr;
  wire        m_chunk    = sel ? b_feat_chunk[0] : a_feat_chunk[0];
  wire        m_busy     = sel ? b_busy : a_busy;
  wire        m_done     = sel ? b_done : a_done;

  int err_cnt = 0;
  int chk_cnt = 0;

  int n_wr, n_rd, n_coo, n_done, done_cyc, wr_hi, unstable, busy_at1;
  int wr_addr [16];
  int wr_chunk[16];
  int wr_cyc  [16];
  int rd_addr [16];
  int rd_cyc  [16];

  task automatic check(input string tag, input int obs, input int exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // cycle 0 is the one in which start is sampled; every later cycle is sampled at its negedge
  task automatic run(input logic s, input logic [6:0] n, input int stall_len,
                     input int restart_at, input int abort_at, input int budget);
    int   stall_left;
    logic prev_en;
    int   prev_addr, prev_chunk;
    sel = s; num_edges = n; ready = 1'b1; stall_left = stall_len;
    n_wr = 0; n_rd = 0; n_coo = 0; n_done = 0; done_cyc = -1; wr_hi = 0; unstable = 0;
    busy_at1 = -1; prev_en = 1'b0; prev_addr = 0; prev_chunk = 0;
    for (int i = 0; i < 16; i++) begin
      wr_addr[i] = -1; wr_chunk[i] = -1; wr_cyc[i] = -1; rd_addr[i] = -1; rd_cyc[i] = -1;
    end
    @(negedge clk);
    start = 1'b1;
    for (int rel = 1; rel <= budget; rel++) begin
      @(negedge clk);
      start = 1'b0;
      ready = 1'b1;
      if (stall_left > 0 && m_wr_en) begin
        ready = 1'b0;
        stall_left--;
      end
      if (rel == 1) busy_at1 = int'(m_busy);
      if (m_rd_en) begin
        if (n_rd < 16) begin rd_addr[n_rd] = int'(m_rd_addr); rd_cyc[n_rd] = rel; end
        n_rd++;
      end
      if (m_wr_en) begin
        wr_hi++;
        if (prev_en && (prev_addr != int'(m_wr_addr) || prev_chunk != int'(m_chunk))) unstable++;
        if (ready) begin
          if (n_wr < 16) begin
            wr_addr[n_wr] = int'(m_wr_addr); wr_chunk[n_wr] = int'(m_chunk); wr_cyc[n_wr] = rel;
          end
          n_wr++;
        end
      end
      prev_en = m_wr_en && !ready; prev_addr = int'(m_wr_addr); prev_chunk = int'(m_chunk);
      if (m_coo_rd) n_coo++;
      if (m_done) begin n_done++; done_cyc = rel; end
      if (rel == restart_at) start = 1'b1;
      if (rel == abort_at) begin
        reset_n = 1'b0;
        #1;
        check("abort_outputs_zero", int'(m_outs), 0);
      end
    end
    start = 1'b0;
    if (abort_at > 0) begin
      @(negedge clk);
      reset_n = 1'b1;
    end
  endtask

  initial begin
    int exp1_addr[8] = '{0, 1, 2, 3, 1, 0, 3, 2};
    int exp1_cyc [8] = '{2, 4, 6, 8, 12, 14, 18, 20};
    int exp1_rd  [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    for (int i = 0; i < 64; i++) begin mem_src[i] = 2'd0; mem_dst[i] = 2'd0; end
    reset_n = 1'b0; start = 1'b0; sel = 1'b0; ready = 1'b1; num_edges = '0;
    repeat (3) @(negedge clk);
    check("reset_outs_a", int'(a_outs), 0);
    check("reset_outs_b", int'(b_outs), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // two undirected edges with self loops
    mem_src[0] = 2'd0; mem_dst[0] = 2'd1; mem_src[1] = 2'd2; mem_dst[1] = 2'd3;
    run(1'b0, 7'd2, 0, 0, 0, 25);
    check("t1_done_cnt", n_done, 1);
    check("t1_done_cyc", done_cyc, 21);
    check("t1_busy_c1", busy_at1, 1);
    check("t1_busy_end", int'(m_busy), 0);
    check("t1_n_wr", n_wr, 8);
    check("t1_n_coo", n_coo, 2);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t1_wr_addr%0d", i), wr_addr[i], exp1_addr[i]);
      check($sformatf("t1_wr_cyc%0d", i), wr_cyc[i], exp1_cyc[i]);
      check($sformatf("t1_rd_addr%0d", i), rd_addr[i], exp1_rd[i]);
    end

    // COO self-edge is not doubled
    mem_src[0] = 2'd2; mem_dst[0] = 2'd2;
    run(1'b0, 7'd1, 0, 0, 0, 16);
    check("t2_done_cyc", done_cyc, 13);
    check("t2_n_wr", n_wr, 5);
    check("t2_n_rd", n_rd, 5);
    check("t2_edge_wr_addr", wr_addr[4], 2);
    check("t2_edge_rd_addr", rd_addr[4], 2);

    // directed edge, latency 3, two chunks
    mem_src[0] = 2'd1; mem_dst[0] = 2'd3;
    run(1'b1, 7'd1, 0, 0, 0, 14);
    check("t3_done_cyc", done_cyc, 11);
    check("t3_n_wr", n_wr, 2);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("t3_wr_addr%0d", i), wr_addr[i], 3);
      check($sformatf("t3_wr_chunk%0d", i), wr_chunk[i], i);
      check($sformatf("t3_rd_addr%0d", i), rd_addr[i], 1);
      check($sformatf("t3_rd_cyc%0d", i), rd_cyc[i], 3 + 4 * i);
      check($sformatf("t3_wr_lat%0d", i), wr_cyc[i] - rd_cyc[i], 3);
    end

    // five-cycle write stall on the first write
    run(1'b1, 7'd1, 5, 0, 0, 20);
    check("t4_done_cyc", done_cyc, 16);
    check("t4_wr_hi", wr_hi, 7);
    check("t4_unstable", unstable, 0);
    check("t4_fire0_cyc", wr_cyc[0], 11);
    check("t4_fire1_cyc", wr_cyc[1], 15);
    check("t4_fire1_chunk", wr_chunk[1], 1);

    // zero edges, no self loops; second start while busy ignored
    run(1'b1, 7'd0, 0, 1, 0, 6);
    check("t5_done_cnt", n_done, 1);
    check("t5_done_cyc", done_cyc, 1);
    check("t5_busy_c1", busy_at1, 1);
    check("t5_strobes", n_rd + wr_hi + n_coo, 0);

    // reset in the middle of the first edge's forward write
    mem_src[0] = 2'd0; mem_dst[0] = 2'd1; mem_src[1] = 2'd2; mem_dst[1] = 2'd3;
    run(1'b0, 7'd2, 0, 0, 12, 30);
    check("t6_no_done", n_done, 0);
    run(1'b0, 7'd2, 0, 0, 0, 25);
    check("t6_fresh_done_cyc", done_cyc, 21);
    check("t6_fresh_n_wr", n_wr, 8);
    check("t6_fresh_last_addr", wr_addr[7], 2);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

`default_nettype wire
